// File: rtl/rv32i_core_wrapper.sv
// ---------------------------------------------------------------------------
// rv32i_core_wrapper
// Single-cycle, non-pipelined RV32I core. Every instruction completes in one
// clock: fetch, decode, execute, memory access and writeback all happen in
// combinational logic, and the state update lands on the next rising edge.
//
// The instruction ROM (imem_r), register file (regs_r) and data RAM (dmem_r)
// are internal arrays. Simulation loads the ROM and inspects registers through
// hierarchical references (the ROM holds one 32-bit word per entry).
//
// Optional feature macro: RV32I_ECALL_HALT_EN
//   defined   : ECALL/EBREAK hold the PC on their own address, so the core
//               re-executes the same side-effect-free instruction until reset.
//   undefined : ECALL/EBREAK behave as NOPs (PC + 4).
// ---------------------------------------------------------------------------
module rv32i_core_wrapper #(
    parameter int unsigned IMEM_DEPTH = 4096,
    parameter int unsigned DMEM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic sys_clk_i,
    input logic rst_n_i
);

    localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Integer ALU shared by OP and OP-IMM. 'alt' selects SUB / SRA.
    function automatic logic [31:0] alu_calc(
        input logic [2:0]  f3,
        input logic        alt,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, ($signed(a) < $signed(b))};
            3'b011:  r = {31'd0, (a < b)};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Branch condition; reserved funct3 codes never take the branch.
    function automatic logic branch_cond(
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic t;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Lane select and sign/zero extension of a loaded word. The halfword lane
    // comes from addr[1] only, so a halfword at an odd address reads the lane
    // that addr[1] names rather than straddling two lanes.
    function automatic logic [31:0] load_extend(
        input logic [2:0]  f3,
        input logic [31:0] word,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'd0;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0] pc_r;
    logic [31:0] regs_r [0:31];
    logic [31:0] imem_r [0:IMEM_DEPTH-1];
    logic [31:0] dmem_r [0:DMEM_DEPTH-1];

    // -----------------------------------------------------------------------
    // Fetch and decode
    // -----------------------------------------------------------------------
    logic [31:0] instr_s;
    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [2:0]  funct3_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [31:0] pc_plus4_s;

    // Fetch index drops the upper PC bits, so fetch wraps modulo the ROM depth.
    assign instr_s  = imem_r[pc_r[IMEM_AW+1:2]];
    assign opcode_s = instr_s[6:0];
    assign rd_s     = instr_s[11:7];
    assign funct3_s = instr_s[14:12];
    assign rs1_s    = instr_s[19:15];
    assign rs2_s    = instr_s[24:20];

    assign imm_i_s = {{20{instr_s[31]}}, instr_s[31:20]};
    assign imm_s_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    assign imm_b_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25],
                      instr_s[11:8], 1'b0};
    assign imm_u_s = {instr_s[31:12], 12'd0};
    assign imm_j_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20],
                      instr_s[30:21], 1'b0};

    // x0 is hard-wired to zero on the read side as well as the write side.
    assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : regs_r[rs1_s];
    assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : regs_r[rs2_s];

    assign pc_plus4_s = pc_r + 32'd4;

    // -----------------------------------------------------------------------
    // Data memory addressing
    // -----------------------------------------------------------------------
    logic [31:0]        mem_addr_s;
    logic [DMEM_AW-1:0] dmem_idx_s;
    logic [31:0]        mem_word_s;
    logic [31:0]        load_data_s;
    logic               unused_addr_s;

    assign mem_addr_s  = rs1_val_s + ((opcode_s == OPC_STORE) ? imm_s_s : imm_i_s);
    assign dmem_idx_s  = mem_addr_s[DMEM_AW+1:2];
    assign mem_word_s  = dmem_r[dmem_idx_s];
    assign load_data_s = load_extend(funct3_s, mem_word_s, mem_addr_s[1:0]);

    // Address bits above the RAM size alias onto the same words.
    assign unused_addr_s = ^mem_addr_s[31:DMEM_AW+2];

    // -----------------------------------------------------------------------
    // Execute
    // -----------------------------------------------------------------------
    logic [31:0] next_pc_s;
    logic        rd_we_s;
    logic [31:0] rd_wdata_s;
    logic [3:0]  dmem_be_s;
    logic [31:0] dmem_wdata_s;

    // Instruction execution: next PC, register writeback and store lanes.
    always_comb begin
        next_pc_s    = pc_plus4_s;
        rd_we_s      = 1'b0;
        rd_wdata_s   = 32'd0;
        dmem_be_s    = 4'b0000;
        dmem_wdata_s = 32'd0;

        case (opcode_s)
            OPC_LUI: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = imm_u_s;
            end
            OPC_AUIPC: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_r + imm_u_s;
            end
            OPC_JAL: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_plus4_s;
                next_pc_s  = pc_r + imm_j_s;
            end
            OPC_JALR: begin
                // Target uses rs1 as read this cycle, so rd == rs1 is safe.
                if (funct3_s == 3'b000) begin
                    rd_we_s    = 1'b1;
                    rd_wdata_s = pc_plus4_s;
                    next_pc_s  = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;
                end else begin
                    rd_we_s    = 1'b0;
                    next_pc_s  = pc_plus4_s;
                end
            end
            OPC_BRANCH: begin
                if (branch_cond(funct3_s, rs1_val_s, rs2_val_s)) begin
                    next_pc_s = pc_r + imm_b_s;
                end else begin
                    next_pc_s = pc_plus4_s;
                end
            end
            OPC_LOAD: begin
                case (funct3_s)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
                        rd_we_s    = 1'b1;
                        rd_wdata_s = load_data_s;
                    end
                    default: rd_we_s = 1'b0;
                endcase
            end
            OPC_STORE: begin
                case (funct3_s)
                    3'b000: begin
                        dmem_be_s    = 4'b0001 << mem_addr_s[1:0];
                        dmem_wdata_s = {4{rs2_val_s[7:0]}};
                    end
                    3'b001: begin
                        dmem_be_s    = mem_addr_s[1] ? 4'b1100 : 4'b0011;
                        dmem_wdata_s = {2{rs2_val_s[15:0]}};
                    end
                    3'b010: begin
                        // Misaligned words use the aligned word.
                        dmem_be_s    = 4'b1111;
                        dmem_wdata_s = rs2_val_s;
                    end
                    default: dmem_be_s = 4'b0000;
                endcase
            end
            OPC_OP_IMM: begin
                // Only SRAI uses instr[30]; ADDI never subtracts.
                rd_we_s    = 1'b1;
                rd_wdata_s = alu_calc(funct3_s, (funct3_s == 3'b101) && instr_s[30],
                                      rs1_val_s, imm_i_s);
            end
            OPC_OP: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = alu_calc(funct3_s, instr_s[30], rs1_val_s, rs2_val_s);
            end
            OPC_FENCE: begin
                rd_we_s = 1'b0;
            end
            OPC_SYSTEM: begin
                // CSR accesses write nothing; ECALL/EBREAK optionally halt.
                rd_we_s = 1'b0;
`ifdef RV32I_ECALL_HALT_EN
                if ((funct3_s == 3'b000) && (instr_s[31:21] == 11'd0) &&
                    (rs1_s == 5'd0) && (rd_s == 5'd0)) begin
                    next_pc_s = pc_r;
                end else begin
                    next_pc_s = pc_plus4_s;
                end
`else
                next_pc_s = pc_plus4_s;
`endif
            end
            default: begin
                // Unknown opcodes fall through as NOPs.
                rd_we_s = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------

    // Program counter: reload on reset, otherwise advance every cycle.
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Register file write port; reset clears all registers and drops writeback.
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (rd_we_s && (rd_s != 5'd0)) begin
            regs_r[rd_s] <= rd_wdata_s;
        end
    end

    // Data RAM byte-enabled write; contents survive reset, no write in reset.
    always_ff @(posedge sys_clk_i) begin
        if (rst_n_i) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_be_s[b]) begin
                    dmem_r[dmem_idx_s][8*b +: 8] <= dmem_wdata_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_core_wrapper.sv
// ---------------------------------------------------------------------------
// Testbench for rv32i_core_wrapper. Each scenario loads a short program into
// the ROM, pushes expected register/PC values to a scoreboard, runs the core a
// known number of cycles and then drains the scoreboard against the core state.
// Index 32 in a scoreboard entry stands for the PC.
// ---------------------------------------------------------------------------
module tb_rv32i_core_wrapper;

    logic sys_clk_i = 1'b0;
    logic rst_n_i   = 1'b0;

    always #5 sys_clk_i = ~sys_clk_i;

    rv32i_core_wrapper dut (
        .sys_clk_i (sys_clk_i),
        .rst_n_i   (rst_n_i)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string       name;
        int          idx;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] prog_q[$];
    int          checks_total  = 0;
    int          checks_passed = 0;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'h13);
    endfunction

    function automatic logic [31:0] state_of(input int idx);
        logic [4:0] r;
        r = idx[4:0];
        if (idx == 32) return dut.pc_r;
        return dut.regs_r[r];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic expect_val(input string name, input int idx, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.idx  = idx;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic start_program();
        @(negedge sys_clk_i);
        rst_n_i = 1'b0;
        for (int i = 0; i < 64; i++) dut.imem_r[i] = NOP;
        for (int i = 0; i < prog_q.size(); i++) dut.imem_r[i] = prog_q[i];
        prog_q.delete();
        repeat (2) @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge sys_clk_i);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        start_program();
        @(negedge sys_clk_i);
        rst_n_i = 1'b0;
        @(posedge sys_clk_i);
        #1;
        expect_val("reset_pc", 32, 32'h0000_0000);
        for (int i = 0; i < 32; i++) expect_val($sformatf("reset_x%0d", i), i, 32'd0);
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
    endtask

    task automatic test_addi();
        prog_q.push_back(addi(5'd1, 5'd0, 12'd5));
        prog_q.push_back(addi(5'd2, 5'd1, 12'hFF9));
        expect_val("addi_x1", 1, 32'd5);
        expect_val("addi_x2", 2, 32'hFFFF_FFFE);
        expect_val("addi_pc", 32, 32'd8);
        start_program();
        run(2);
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
    endtask

    task automatic test_x0_lui();
        prog_q.push_back(addi(5'd0, 5'd0, 12'd9));
        prog_q.push_back(enc_u(20'h80000, 5'd5, 7'h37));
        prog_q.push_back(addi(5'd6, 5'd5, 12'hFFF));
        prog_q.push_back(enc_u(20'h00001, 5'd7, 7'h17));
        expect_val("x0_zero", 0, 32'd0);
        expect_val("lui_x5", 5, 32'h8000_0000);
        expect_val("wrap_x6", 6, 32'h7FFF_FFFF);
        expect_val("auipc_x7", 7, 32'h0000_100C);
        start_program();
        run(4);
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
    endtask

    task automatic test_mem();
        prog_q.push_back(addi(5'd1, 5'd0, 12'hFFF));
        prog_q.push_back(enc_s(12'd0, 5'd1, 5'd0, 3'b010));
        prog_q.push_back(addi(5'd2, 5'd0, 12'h012));
        prog_q.push_back(enc_s(12'd1, 5'd2, 5'd0, 3'b000));
        prog_q.push_back(enc_i(12'd0, 5'd0, 3'b000, 5'd3, 7'h03));
        prog_q.push_back(enc_i(12'd1, 5'd0, 3'b100, 5'd4, 7'h03));
        prog_q.push_back(enc_i(12'd0, 5'd0, 3'b001, 5'd5, 7'h03));
        prog_q.push_back(enc_i(12'd0, 5'd0, 3'b010, 5'd6, 7'h03));
        prog_q.push_back(enc_i(12'd2, 5'd0, 3'b001, 5'd7, 7'h03));
        prog_q.push_back(enc_i(12'd1, 5'd0, 3'b101, 5'd8, 7'h03));
        prog_q.push_back(enc_s(12'd3, 5'd2, 5'd0, 3'b001));
        prog_q.push_back(enc_i(12'd0, 5'd0, 3'b010, 5'd9, 7'h03));
        prog_q.push_back(enc_i(12'd2, 5'd0, 3'b000, 5'd11, 7'h03));
        expect_val("lb_x3", 3, 32'hFFFF_FFFF);
        expect_val("lbu_x4", 4, 32'h0000_0012);
        expect_val("lh_x5", 5, 32'h0000_12FF);
        expect_val("lw_x6", 6, 32'hFFFF_12FF);
        expect_val("lh_hi_x7", 7, 32'hFFFF_FFFF);
        expect_val("lhu_odd_x8", 8, 32'h0000_12FF);
        expect_val("sh_odd_x9", 9, 32'h0012_12FF);
        expect_val("lb2_x11", 11, 32'h0000_0012);
        start_program();
        run(13);
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
    endtask

    task automatic test_branch_jal();
        prog_q.push_back(addi(5'd1, 5'd0, 12'hFFF));
        prog_q.push_back(enc_b(13'd8, 5'd1, 5'd0, 3'b110));
        prog_q.push_back(addi(5'd2, 5'd0, 12'd1));
        prog_q.push_back(enc_j(21'd8, 5'd3));
        prog_q.push_back(addi(5'd4, 5'd0, 12'd1));
        expect_val("bltu_skip_x2", 2, 32'd0);
        expect_val("jal_skip_x4", 4, 32'd0);
        expect_val("jal_link_x3", 3, 32'h0000_0010);
        expect_val("jal_pc", 32, 32'd24);
        start_program();
        run(4);
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
    endtask

    task automatic test_signed_branch();
        prog_q.push_back(addi(5'd1, 5'd0, 12'hFFF));
        prog_q.push_back(enc_b(13'd8, 5'd0, 5'd1, 3'b100));
        prog_q.push_back(addi(5'd2, 5'd0, 12'd1));
        prog_q.push_back(enc_b(13'd8, 5'd0, 5'd1, 3'b101));
        prog_q.push_back(addi(5'd3, 5'd0, 12'd3));
        prog_q.push_back(enc_b(13'd8, 5'd0, 5'd0, 3'b000));
        prog_q.push_back(addi(5'd4, 5'd0, 12'd4));
        prog_q.push_back(enc_b(13'd8, 5'd0, 5'd1, 3'b111));
        prog_q.push_back(addi(5'd5, 5'd0, 12'd5));
        expect_val("blt_taken_x2", 2, 32'd0);
        expect_val("bge_fall_x3", 3, 32'd3);
        expect_val("beq_taken_x4", 4, 32'd0);
        expect_val("bgeu_taken_x5", 5, 32'd0);
        expect_val("branch_pc", 32, 32'd36);
        start_program();
        run(6);
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
    endtask

    task automatic test_jalr();
        prog_q.push_back(addi(5'd5, 5'd0, 12'd13));
        prog_q.push_back(enc_i(12'd0, 5'd5, 3'b000, 5'd5, 7'h67));
        prog_q.push_back(addi(5'd6, 5'd0, 12'd1));
        prog_q.push_back(addi(5'd7, 5'd5, 12'd0));
        expect_val("jalr_link_x5", 5, 32'd8);
        expect_val("jalr_skip_x6", 6, 32'd0);
        expect_val("jalr_x7", 7, 32'd8);
        expect_val("jalr_pc", 32, 32'd16);
        start_program();
        run(3);
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
    endtask

    task automatic test_alu();
        for (int it = 0; it < 4; it++) begin
            logic [31:0] a, b, sa, sb_v, hi;
            logic [11:0] imm;
            logic [4:0]  sh;
            case (it)
                0: begin a = 32'h8000_0000; b = 32'h0000_0001; imm = 12'hFFF; sh = 5'd31; end
                1: begin a = 32'h7FFF_FFFF; b = 32'hFFFF_FFFF; imm = 12'h800; sh = 5'd0; end
                default: begin
                    a = $urandom; b = $urandom; imm = 12'($urandom); sh = 5'($urandom);
                end
            endcase
            sa = {{20{imm[11]}}, imm};
            hi = (a + 32'h800) >> 12;
            prog_q.push_back(enc_u(hi[19:0], 5'd1, 7'h37));
            prog_q.push_back(addi(5'd1, 5'd1, a[11:0]));
            hi = (b + 32'h800) >> 12;
            prog_q.push_back(enc_u(hi[19:0], 5'd2, 7'h37));
            prog_q.push_back(addi(5'd2, 5'd2, b[11:0]));
            prog_q.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd10));
            prog_q.push_back(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd11));
            prog_q.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd12));
            prog_q.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd13));
            prog_q.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd14));
            prog_q.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd15));
            prog_q.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd16));
            prog_q.push_back(enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd17));
            prog_q.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd18));
            prog_q.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd19));
            prog_q.push_back(enc_i(imm, 5'd1, 3'b010, 5'd20, 7'h13));
            prog_q.push_back(enc_i(imm, 5'd1, 3'b011, 5'd21, 7'h13));
            prog_q.push_back(enc_i(imm, 5'd1, 3'b100, 5'd22, 7'h13));
            prog_q.push_back(enc_i(imm, 5'd1, 3'b110, 5'd23, 7'h13));
            prog_q.push_back(enc_i(imm, 5'd1, 3'b111, 5'd24, 7'h13));
            prog_q.push_back(enc_i({7'h00, sh}, 5'd1, 3'b001, 5'd25, 7'h13));
            prog_q.push_back(enc_i({7'h00, sh}, 5'd1, 3'b101, 5'd26, 7'h13));
            prog_q.push_back(enc_i({7'h20, sh}, 5'd1, 3'b101, 5'd27, 7'h13));
            prog_q.push_back(enc_i(imm, 5'd1, 3'b000, 5'd28, 7'h13));
            sb_v = b;
            expect_val("add", 10, a + sb_v);
            expect_val("sub", 11, a - sb_v);
            expect_val("sll", 12, a << sb_v[4:0]);
            expect_val("slt", 13, ($signed(a) < $signed(sb_v)) ? 32'd1 : 32'd0);
            expect_val("sltu", 14, (a < sb_v) ? 32'd1 : 32'd0);
            expect_val("xor", 15, a ^ sb_v);
            expect_val("srl", 16, a >> sb_v[4:0]);
            expect_val("sra", 17, 32'($signed(a) >>> sb_v[4:0]));
            expect_val("or", 18, a | sb_v);
            expect_val("and", 19, a & sb_v);
            expect_val("slti", 20, ($signed(a) < $signed(sa)) ? 32'd1 : 32'd0);
            expect_val("sltiu", 21, (a < sa) ? 32'd1 : 32'd0);
            expect_val("xori", 22, a ^ sa);
            expect_val("ori", 23, a | sa);
            expect_val("andi", 24, a & sa);
            expect_val("slli", 25, a << sh);
            expect_val("srli", 26, a >> sh);
            expect_val("srai", 27, 32'($signed(a) >>> sh));
            expect_val("addi", 28, a + sa);
            expect_val("alu_pc", 32, 32'd92);
            start_program();
            run(23);
            while (sb_q.size() > 0) begin
                sb_t e = sb_q.pop_front();
                logic [31:0] act = state_of(e.idx);
                checks_total++;
                if (act !== e.exp)
                    $display("FAIL %s[%0d]: got %h expected %h (a=%h b=%h imm=%h sh=%0d)",
                             e.name, it, act, e.exp, a, b, imm, sh);
                else checks_passed++;
            end
        end
    endtask

    task automatic test_system_nop();
        prog_q.push_back(32'h0FF0_000F);
        prog_q.push_back(enc_i(12'hC00, 5'd0, 3'b010, 5'd6, 7'h73));
        prog_q.push_back(32'h0000_0073);
        prog_q.push_back(addi(5'd7, 5'd0, 12'd9));
        prog_q.push_back(32'hFFFF_FFFF);
        prog_q.push_back(addi(5'd8, 5'd0, 12'd1));
        expect_val("csr_no_write_x6", 6, 32'd0);
`ifdef RV32I_ECALL_HALT_EN
        expect_val("halt_x7", 7, 32'd0);
        expect_val("halt_x8", 8, 32'd0);
        expect_val("halt_pc", 32, 32'd8);
`else
        expect_val("ecall_nop_x7", 7, 32'd9);
        expect_val("illegal_nop_x8", 8, 32'd1);
        expect_val("sys_pc", 32, 32'd24);
`endif
        start_program();
        run(6);
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
    endtask

    task automatic test_pc_wrap();
        prog_q.push_back(enc_j(21'd16380, 5'd0));
        start_program();
        dut.imem_r[4095] = addi(5'd9, 5'd0, 12'h055);
        expect_val("wrap_x9", 9, 32'h0000_0055);
        expect_val("wrap_pc", 32, 32'd32764);
        run(3);
        dut.imem_r[4095] = NOP;
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
    endtask

    task automatic test_mid_reset();
        prog_q.push_back(addi(5'd1, 5'd0, 12'd1));
        prog_q.push_back(addi(5'd2, 5'd0, 12'd2));
        prog_q.push_back(addi(5'd3, 5'd0, 12'd3));
        start_program();
        run(2);
        @(negedge sys_clk_i);
        rst_n_i = 1'b0;
        @(posedge sys_clk_i);
        #1;
        expect_val("midrst_pc", 32, 32'd0);
        expect_val("midrst_x1", 1, 32'd0);
        expect_val("midrst_x2", 2, 32'd0);
        expect_val("midrst_abort_x3", 3, 32'd0);
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
        @(negedge sys_clk_i);
        rst_n_i = 1'b1;
        expect_val("restart_x1", 1, 32'd1);
        expect_val("restart_x2", 2, 32'd0);
        expect_val("restart_pc", 32, 32'd4);
        run(1);
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            logic [31:0] act = state_of(e.idx);
            checks_total++;
            if (act !== e.exp) $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            else checks_passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) dut.imem_r[i] = NOP;
        test_reset();
        test_addi();
        test_x0_lui();
        test_mem();
        test_branch_jal();
        test_signed_branch();
        test_jalr();
        test_alu();
        test_system_nop();
        test_pc_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/rv32i_core_wrapper.md
RV32I_CORE_WRAPPER -- requirements
Module: rv32i_core_wrapper

Interface
REQ-001 Parameter IMEM_DEPTH, default 4096: instruction ROM size in 32-bit words.
REQ-002 Parameter DMEM_DEPTH, default 4096: data RAM size in 32-bit words.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-004 Port sys_clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 No other ports; the instruction ROM and register file are internal arrays that simulation loads and inspects hierarchically.

Function
REQ-007 Single-cycle, non-pipelined RV32I core: one instruction completes per clock, CPI = 1.
REQ-008 Instruction ROM: combinational read at word index pc[log2(IMEM_DEPTH)+1:2]; preloadable by $readmemh; holds one hex word per line.
REQ-009 PC fetch beyond IMEM_DEPTH wraps modulo the depth.
REQ-010 Register file: 32 x 32 bits, two combinational read ports, one write port written on the rising edge.
REQ-011 Register x0 reads 0 at all times; writes to x0 are discarded.
REQ-012 Supported instructions: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
REQ-013 Arithmetic is modulo 2^32 with no overflow trap; shift amount is rs2[4:0] or shamt.
REQ-014 SLT/SLTI compare signed; SLTU/SLTIU compare unsigned, with the immediate sign-extended before the unsigned compare.
REQ-015 Next PC is pc+4 by default; on a taken branch or JAL it is pc+imm; on JALR it is (rs1+imm) & ~1.
REQ-016 JAL and JALR write pc+4 to rd; rd equal to rs1 uses the old rs1 value.
REQ-017 Data RAM: byte-addressed, combinational read, byte-enabled write on the rising edge, word index addr[log2(DMEM_DEPTH)+1:2].
REQ-018 Byte lane is selected by addr[1:0] and halfword lane by addr[1]; LB/LH sign-extend and LBU/LHU zero-extend.
REQ-019 Misaligned LW/SW use the aligned word; misaligned LH/SH with addr[0]=1 use the lane given by addr[1].
REQ-020 FENCE, FENCE.I and CSR (SYSTEM funct3!=0) instructions execute as NOPs and write no register.
REQ-021 Illegal or unknown opcodes execute as NOPs with PC+4.

Reset
REQ-022 While rst_n_i=0 at a rising edge: PC <= RESET_PC and all 32 registers <= 0; no memory write occurs.
REQ-023 Data RAM and instruction ROM contents are not altered by reset.
REQ-024 The first instruction executes in the first rising edge with rst_n_i=1; reset asserted mid-program aborts the current instruction's writeback.

Configuration
REQ-025 Macro RV32I_ECALL_HALT_EN: when defined, ECALL/EBREAK freeze the PC at the ECALL/EBREAK address with no further state change until reset.
REQ-026 When RV32I_ECALL_HALT_EN is undefined, ECALL/EBREAK are NOPs (PC+4).

Verification
REQ-027 Scenario: program "addi x1,x0,5; addi x2,x1,-7" -> after 2 executed cycles, x1=5 and x2=0xFFFFFFFE.
REQ-028 Scenario: "addi x0,x0,9; lui x5,0x80000; addi x6,x5,-1" -> x0=0, x5=0x80000000, x6=0x7FFFFFFF (wrap).
REQ-029 Scenario: "addi x1,x0,-1; sw x1,0(x0); addi x2,x0,0x12; sb x2,1(x0); lb x3,0(x0); lbu x4,1(x0); lh x5,0(x0)" -> x3=0xFFFFFFFF, x4=0x12, x5=0x000012FF.
REQ-030 Scenario: "addi x1,x0,-1; bltu x0,x1,+8; addi x2,x0,1; jal x3,+8; addi x4,x0,1" (ROM at 0) -> x2=0, x4=0, x3=0x10.
REQ-031 Scenario: riscv-tests rv32ui-p-addi image loaded via $readmemh with rst_n_i low for >=2 cycles -> x26 becomes nonzero; 200 ns later x27=1 (pass); otherwise x3 holds the failing test number.
REQ-032 Scenario: assert rst_n_i=0 for one edge mid-program -> next cycle PC=RESET_PC and x1..x31=0.
